// File: rtl/audio_pkg.sv
// audio_pkg: shared widths, sample type and mix helper for the I2S transmitter
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int IN_W = 15;
  localparam int FRAME_W = 9;
  localparam int SLOT_W = 5;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
  function automatic sample_t mix_fn(sample_t a, sample_t b);
    logic signed [SAMPLE_W+1:0] t;
    t = ((SAMPLE_W+2)'(a) <<< 1) + (SAMPLE_W+2)'(a) + (SAMPLE_W+2)'(b);
    return SAMPLE_W'(t >>> 2);
  endfunction
endpackage

// File: rtl/audio_i2s_tx_if.sv
// audio_i2s_tx_if: sample inputs and CODEC-side serial/clock outputs
interface audio_i2s_tx_if;
  import audio_pkg::*;
  logic [IN_W-1:0] ldata;
  logic [IN_W-1:0] rdata;
  logic exchan;
  logic mix;
  logic sample_stb;
  logic aud_xck;
  logic aud_bclk;
  logic aud_daclrck;
  logic aud_dacdat;
  modport master (
    input ldata, rdata, exchan, mix,
    output sample_stb, aud_xck, aud_bclk, aud_daclrck, aud_dacdat
  );
  modport slave (
    output ldata, rdata, exchan, mix,
    input sample_stb, aud_xck, aud_bclk, aud_daclrck, aud_dacdat
  );
endinterface

// File: rtl/audio_i2s_shifter.sv
// audio_i2s_shifter: 16-bit MSB-first shift register, time-shared by both channels
module audio_i2s_shifter
  import audio_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    load,
  input  logic    shift,
  input  sample_t din,
  output logic    msb
);
  sample_t sh;
  always_ff @(posedge clk)
    if (rst) sh <= '0;
    else if (load) sh <= din;
    else if (shift) sh <= {sh[SAMPLE_W-2:0], 1'b0};
  assign msb = sh[SAMPLE_W-1];
endmodule

// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: WM8731 I2S transmitter, clk/512 frames; define AUDIO_MIX_EN to compile in the centred mix
module audio_i2s_tx
  import audio_pkg::*;
(
  input logic clk,
  input logic rst,
  audio_i2s_tx_if.master bus
);
  logic [FRAME_W-1:0] cnt;
  logic [SLOT_W-1:0] slot;
  sample_t l_q, r_q, l_w, r_w, l_n, r_n;
  logic stb_q, dat_q, msb;
  assign slot = cnt[7:3];
  always_comb begin
    l_w = bus.exchan ? {bus.rdata, 1'b0} : {bus.ldata, 1'b0};
    r_w = bus.exchan ? {bus.ldata, 1'b0} : {bus.rdata, 1'b0};
`ifdef AUDIO_MIX_EN
    l_n = bus.mix ? mix_fn(l_w, r_w) : l_w;
    r_n = bus.mix ? mix_fn(r_w, l_w) : r_w;
`else
    l_n = l_w;
    r_n = r_w;
`endif
  end
  // strobe is registered one cycle early so it is high exactly on the capture cycle
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      l_q <= '0;
      r_q <= '0;
      stb_q <= 1'b0;
      dat_q <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      stb_q <= cnt == FRAME_W'(510);
      if (&cnt) begin
        l_q <= l_n;
        r_q <= r_n;
      end
      if (&cnt[2:0]) dat_q <= msb;
    end
  audio_i2s_shifter u_shifter (
    .clk(clk),
    .rst(rst),
    .load(slot == '0 && cnt[2:0] == '0),
    .shift(&cnt[2:0]),
    .din(cnt[8] ? r_q : l_q),
    .msb(msb)
  );
  assign bus.sample_stb = stb_q;
  assign bus.aud_xck = cnt[0];
  assign bus.aud_bclk = cnt[2];
  assign bus.aud_daclrck = cnt[8];
  assign bus.aud_dacdat = dat_q;
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: vector table plus frame-level reference model for audio_i2s_tx
module tb_audio_i2s_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  audio_i2s_tx_if bus();
  audio_i2s_tx dut (.clk(clk), .rst(rst), .bus(bus.master));
  int total = 0;
  int passed = 0;
  int pos = 0;
  logic [15:0] wl = '0;
  logic [15:0] wr = '0;
  typedef struct {
    logic [14:0] ld;
    logic [14:0] rd;
    logic ex;
    logic mx;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;
  vec_t vecs[11];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (frame pos %0d)", name, act, exp, pos);
  endtask
  function automatic logic [31:0] model_words(input logic [14:0] ld, input logic [14:0] rd,
                                              input logic ex, input logic mx);
    int a, b, t;
    a = $signed(ld) * 2;
    b = $signed(rd) * 2;
    if (ex) begin
      t = a;
      a = b;
      b = t;
    end
`ifdef AUDIO_MIX_EN
    if (mx) begin
      t = a;
      a = (3 * a + b) >>> 2;
      b = (3 * b + t) >>> 2;
    end
`endif
    return {a[15:0], b[15:0]};
  endfunction
  function automatic logic exp_dat(input int p, input logic [15:0] l, input logic [15:0] r);
    int s;
    logic [15:0] w;
    s = (p % 256) / 8;
    w = (p >= 256) ? r : l;
    return (s >= 1 && s <= 16) ? w[16 - s] : 1'b0;
  endfunction
  always @(posedge clk)
    if (rst) begin
      pos <= 0;
      wl <= '0;
      wr <= '0;
    end else begin
      if (pos == 511) {wl, wr} <= model_words(bus.ldata, bus.rdata, bus.exchan, bus.mix);
      pos <= (pos + 1) % 512;
    end
  always @(negedge clk)
    chk("outputs", {27'd0, bus.aud_xck, bus.aud_bclk, bus.aud_daclrck, bus.sample_stb, bus.aud_dacdat},
        {27'd0, 1'(pos % 2), 1'((pos / 4) % 2), 1'(pos / 256), pos == 511, exp_dat(pos, wl, wr)});
  task automatic goto_pos(input int p);
    for (int k = 0; k < 600 && pos != p; k++) @(negedge clk);
  endtask
  task automatic apply(input vec_t v);
    bus.ldata = v.ld;
    bus.rdata = v.rd;
    bus.exchan = v.ex;
    bus.mix = v.mx;
  endtask
  task automatic measure(input bit lr, output int per);
    logic prev, cur;
    int t0;
    per = 0;
    t0 = -1;
    prev = lr ? bus.aud_daclrck : bus.aud_bclk;
    for (int k = 0; k < 1200 && per == 0; k++) begin
      @(negedge clk);
      cur = lr ? bus.aud_daclrck : bus.aud_bclk;
      if (cur && !prev) begin
        if (t0 < 0) t0 = k;
        else per = k - t0;
      end
      prev = cur;
    end
  endtask
  task automatic run_frame(input bit scramble, output logic [15:0] dl, output logic [15:0] dr,
                           output logic pad);
    logic [31:0] bits[2];
    bits[0] = '1;
    bits[1] = '1;
    for (int i = 0; i < 512; i++) begin
      if (pos % 8 == 4) bits[pos / 256][(pos % 256) / 8] = bus.aud_dacdat;
      if (scramble && (i == 100 || i == 300)) begin
        bus.ldata = 15'($urandom);
        bus.rdata = 15'($urandom);
        bus.exchan = 1'($urandom);
        bus.mix = 1'($urandom);
      end
      @(negedge clk);
    end
    for (int j = 0; j < 16; j++) begin
      dl[j] = bits[0][16 - j];
      dr[j] = bits[1][16 - j];
    end
    pad = !bits[0][0] && !bits[1][0] && bits[0][31:17] == '0 && bits[1][31:17] == '0;
  endtask
  initial begin
    int k, per;
    logic [15:0] dl, dr;
    logic pad;
    vecs[0] = '{15'h1000, 15'h7FFF, 1'b0, 1'b0, 16'h2000, 16'hFFFE};
    vecs[1] = '{15'h1000, 15'h7FFF, 1'b1, 1'b0, 16'hFFFE, 16'h2000};
`ifdef AUDIO_MIX_EN
    vecs[2] = '{15'h1000, 15'h0000, 1'b0, 1'b1, 16'h1800, 16'h0800};
    vecs[3] = '{15'h7FFF, 15'h0000, 1'b0, 1'b1, 16'hFFFE, 16'hFFFF};
    vecs[4] = '{15'h1000, 15'h7FFF, 1'b0, 1'b1, 16'h17FF, 16'h07FE};
`else
    vecs[2] = '{15'h1000, 15'h0000, 1'b0, 1'b1, 16'h2000, 16'h0000};
    vecs[3] = '{15'h7FFF, 15'h0000, 1'b0, 1'b1, 16'hFFFE, 16'h0000};
    vecs[4] = '{15'h1000, 15'h7FFF, 1'b0, 1'b1, 16'h2000, 16'hFFFE};
`endif
    for (int i = 5; i < 11; i++) begin
      vecs[i].ld = 15'($urandom);
      vecs[i].rd = 15'($urandom);
      vecs[i].ex = 1'($urandom);
      vecs[i].mx = 1'($urandom);
      {vecs[i].el, vecs[i].er} = model_words(vecs[i].ld, vecs[i].rd, vecs[i].ex, vecs[i].mx);
    end
    bus.ldata = '0;
    bus.rdata = '0;
    bus.exchan = 1'b0;
    bus.mix = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.sample_stb && k < 600);
    chk("first_stb", k, 511);
    measure(1'b0, per);
    chk("bclk_period", per, 8);
    measure(1'b1, per);
    chk("lrclk_period", per, 512);
    for (int i = 0; i < 11; i++) begin
      goto_pos(510);
      apply(vecs[i]);
      @(negedge clk);
      @(negedge clk);
      run_frame(1'b1, dl, dr, pad);
      chk($sformatf("vec%0d_left", i), dl, vecs[i].el);
      chk($sformatf("vec%0d_right", i), dr, vecs[i].er);
      chk($sformatf("vec%0d_pad", i), pad, 1'b1);
    end
    goto_pos(510);
    apply(vecs[0]);
    goto_pos(300);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    apply(vecs[1]);
    rst = 1'b0;
    run_frame(1'b0, dl, dr, pad);
    chk("post_reset_left", dl, 16'h0000);
    chk("post_reset_right", dr, 16'h0000);
    run_frame(1'b0, dl, dr, pad);
    chk("after_reset_left", dl, vecs[1].el);
    chk("after_reset_right", dr, vecs[1].er);
    chk("after_reset_pad", pad, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
